// File: rtl/uart_bus_responder.sv
// UART bus responder: CPU-visible DATA/STATUS/DIVISOR registers, a TX FIFO
// feeding an 8N1 serializer, and a one-byte RX holding register.
//
// Serializer states:
//   state    | meaning
//   ST_IDLE  | line high; pops the FIFO head when a byte is waiting
//   ST_START | start bit (line low) for one bit time
//   ST_DATA  | eight data bits, LSB first, one bit time each
//   ST_STOP  | stop bit (line high) for one bit time
module uart_bus_responder #(
    parameter int          TX_DEPTH        = 16,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd868
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        chip_select_i,
    input  logic [3:0]  addr_i,
    input  logic        read_enable_i,
    input  logic        write_enable_i,
    input  logic [31:0] write_data_i,
    input  logic [3:0]  write_mask_i,
    output logic [31:0] read_data_o,
    output logic        tx_o,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        irq_o
);

    localparam int AW = $clog2(TX_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(TX_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_read_data;
    logic        r_irq;
    logic [7:0]  r_rx_byte;
    logic        r_rx_valid;
    logic        r_rx_overrun;
    logic        r_tx_overflow;
    logic [15:0] r_divisor;
    logic [7:0]  r_fifo [TX_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_cnt;
    logic [15:0] r_baud_cnt;

    logic        w_rd, w_wr;
    logic [1:0]  w_word;
    logic        w_rd_data, w_st_wr, w_div_wr;
    logic        w_push_req, w_push, w_drop, w_pop;
    logic        w_empty, w_full, w_busy, w_bit_end, w_tx;
    logic [15:0] w_div_raw, w_div_new;
    logic [31:0] w_status, w_rd_mux;
    logic        w_unused;

    // Byte-lane bits the register map never looks at.
    assign w_unused = ^{addr_i[1:0], write_data_i[31:16]};

    assign w_rd       = chip_select_i & read_enable_i;
    assign w_wr       = chip_select_i & write_enable_i;
    assign w_word     = addr_i[3:2];
    assign w_rd_data  = w_rd & (w_word == 2'd0);
    assign w_st_wr    = w_wr & (w_word == 2'd1) & write_mask_i[0];
    assign w_div_wr   = w_wr & (w_word == 2'd2);
    assign w_push_req = w_wr & (w_word == 2'd0) & write_mask_i[0];
    // Acceptance uses the count before any same-cycle pop.
    assign w_push     = w_push_req & (r_count < DEPTH_C);
    assign w_drop     = w_push_req & ~(r_count < DEPTH_C);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == DEPTH_C);
    assign w_busy     = (r_state != ST_IDLE);
    assign w_bit_end  = (r_baud_cnt == 16'd0);

    assign w_div_raw = {write_mask_i[1] ? write_data_i[15:8] : r_divisor[15:8],
                        write_mask_i[0] ? write_data_i[7:0]  : r_divisor[7:0]};
    assign w_div_new = (w_div_raw == 16'd0) ? 16'd1 : w_div_raw;

    // Read mux over the current register contents.
    always_comb begin
        w_status = {26'd0, r_tx_overflow, r_rx_overrun, r_rx_valid, w_busy, w_empty, w_full};
        w_rd_mux = 32'd0;
        case (w_word)
            2'd0:    w_rd_mux = {23'd0, r_rx_valid, r_rx_byte};
            2'd1:    w_rd_mux = w_status;
            2'd2:    w_rd_mux = {16'd0, r_divisor};
            default: w_rd_mux = 32'd0;
        endcase
    end

    // Registered read data (zero after any non-read) and registered interrupt level.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_read_data <= 32'd0;
            r_irq       <= 1'b0;
        end else begin
            r_read_data <= w_rd ? w_rd_mux : 32'd0;
            r_irq       <= r_rx_valid | (w_empty & ~w_busy);
        end
    end

    // RX holding register; a new byte arriving with a DATA read is not an overrun.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_rx_byte    <= 8'd0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            if (rx_valid_i) begin
                r_rx_byte  <= rx_data_i;
                r_rx_valid <= 1'b1;
            end else if (w_rd_data) begin
                r_rx_valid <= 1'b0;
            end
            if (rx_valid_i && r_rx_valid && !w_rd_data)
                r_rx_overrun <= 1'b1;
            else if (w_rd_data || (w_st_wr && write_data_i[4]))
                r_rx_overrun <= 1'b0;
        end
    end

    // Sticky TX overflow flag, write-1-to-clear through STATUS.
    always_ff @(posedge clk_i) begin
        if (!reset_ni)
            r_tx_overflow <= 1'b0;
        else if (w_drop)
            r_tx_overflow <= 1'b1;
        else if (w_st_wr && write_data_i[5])
            r_tx_overflow <= 1'b0;
    end

    // Baud divisor; zero is promoted to one so a bit always lasts at least a clock.
    always_ff @(posedge clk_i) begin
        if (!reset_ni)
            r_divisor <= DEFAULT_DIVISOR;
        else if (w_div_wr)
            r_divisor <= w_div_new;
    end

    // FIFO storage; contents are don't-care until the count says otherwise.
    always_ff @(posedge clk_i) begin
        if (w_push)
            r_fifo[r_wptr] <= write_data_i[7:0];
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Serializer state register.
    always_ff @(posedge clk_i) begin
        if (!reset_ni)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Serializer next state, FIFO pop and line level.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_tx        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                w_tx = 1'b0;
                if (w_bit_end) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                w_tx = r_shift[0];
                if (w_bit_end && (r_bit_cnt == 3'd0)) w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (w_bit_end) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bit-time down-counter, bit counter and shift register; the divisor is
    // sampled only when a bit starts, so a change takes effect at the next bit.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_shift    <= 8'd0;
            r_bit_cnt  <= 3'd0;
            r_baud_cnt <= 16'd0;
        end else if (w_pop) begin
            r_shift    <= r_fifo[r_rptr];
            r_bit_cnt  <= 3'd7;
            r_baud_cnt <= r_divisor - 16'd1;
        end else if (w_busy) begin
            if (w_bit_end) begin
                r_baud_cnt <= r_divisor - 16'd1;
                if (r_state == ST_DATA) begin
                    r_shift   <= {1'b0, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt - 3'd1;
                end
            end else begin
                r_baud_cnt <= r_baud_cnt - 16'd1;
            end
        end
    end

    assign read_data_o = r_read_data;
    assign tx_o        = w_tx;
    assign irq_o       = r_irq;

endmodule
